msrv32_pc_fetch_ctrl: RTL
=========================

// Module: msrv32_pc_fetch_ctrl
// PURPOSE
// Parametrised PC register plus instruction-fetch controller; next generation of the PC register stage.
// Holds the fetch PC and issues one outstanding request at a time on a req/gnt + rvalid memory port.
// Buffers the returned instruction until the decode stage accepts it.
// Applies trap/redirect updates with priority and kills in-flight responses.
// PARAMETERS
// XLEN         32            PC / data width
// BOOT_ADDR    32'h00000000  PC value after reset
// RESET_DELAY  2             idle cycles after reset release before first request (0 = fetch immediately)
// CNT_W        32            width of accepted-instruction counter
// PORTS
// clk_in             in   1     clock, all state on posedge
// rst_in             in   1     reset, asynchronous, active-low
// trap_in            in   1     load trap_vec_in into PC (highest priority)
// trap_vec_in        in   XLEN  trap target; bits[1:0] forced to 0
// redirect_in        in   1     branch/jump redirect strobe
// redirect_pc_in     in   XLEN  redirect target
// stall_in           in   1     decode cannot accept instr this cycle
// imem_req_out       out  1     fetch request
// imem_addr_out      out  XLEN  fetch address (= pc_out)
// imem_gnt_in        in   1     request accepted this cycle
// imem_rvalid_in     in   1     response data valid (exactly one per grant, >=1 cycle after gnt)
// imem_rdata_in      in   32    response instruction
// pc_out             out  XLEN  next fetch PC
// instr_out          out  32    buffered instruction
// instr_pc_out       out  XLEN  PC of instr_out
// instr_valid_out    out  1     instr_out valid
// misaligned_out     out  1     1-cycle pulse: redirect target bits[1:0]!=0
// misaligned_addr_out out XLEN  captured bad target (held until next misalign)
// fetch_cnt_out      out  CNT_W instructions accepted by decode, wraps
// BEHAVIOUR
// Reset (async assert, sync release): pc_out=BOOT_ADDR; all other outputs 0; state=BOOT; delay counter=0.
// States: BOOT, REQ, WAIT, KILL, HOLD.
// - BOOT: imem_req_out=0. Leave for REQ after RESET_DELAY cycles; if RESET_DELAY=0, go to REQ on the first clock.
// - REQ: imem_req_out=1, imem_addr_out=pc_out. gnt -> WAIT. Address may change while ungranted.
// - WAIT: req=0. rvalid -> instr_out=rdata, instr_pc_out=pc_out, instr_valid_out=1, pc_out+=4, go HOLD.
// - HOLD: instr_valid_out=1, instr_out stable. Accept = valid & !stall_in -> valid=0, fetch_cnt+1, go REQ.
// - KILL: response belongs to a discarded request. On rvalid, drop data and go REQ.
// Update priority each cycle: trap_in > redirect_in > sequential.
// - Trap: pc_out={trap_vec_in[XLEN-1:2],2'b00}. No misaligned check.
// - Redirect, target bits[1:0]==0: pc_out=target.
// - Redirect, target misaligned: PC and state unchanged; misaligned_out=1 next cycle; misaligned_addr_out=target.
// Effect of a valid trap/redirect by state (all next-cycle):
// - BOOT: PC updated; delay continues.
// - REQ with gnt the same cycle: go KILL.
// - REQ without gnt: stay REQ; the new address is presented.
// - WAIT without rvalid: go KILL. WAIT with rvalid: data dropped, go REQ.
// - KILL: PC updated, remain KILL.
// - HOLD: instr_valid_out=0, no count, go REQ.
// Sequential +4 wraps modulo 2^XLEN. fetch_cnt_out wraps modulo 2^CNT_W.
// Minimum latency: REQ->gnt->rvalid->HOLD, so 1 instr per 3 cycles with zero-wait memory; throughput is not a goal.
// Reset mid-transaction: outstanding response ignored. BOOT does not track rvalid, so the bench guarantees no stale rvalid.
// TESTING
// 1 Reset release, RESET_DELAY=2: req rises cycle 3 with addr 0x0; gnt, rvalid=0x00000013 -> instr_valid, instr_pc=0x0, pc_out=0x4.
// 2 stall_in high 5 cycles in HOLD: instr_out/instr_pc stable, no req; stall low -> fetch_cnt 0->1, req addr 0x4.
// 3 redirect_in to 0x100 in WAIT: rvalid data discarded (no instr_valid); next req addr 0x100.
// 4 redirect_pc_in=0x102: misaligned_out pulse, misaligned_addr_out=0x102, pc_out unchanged.
// 5 trap_in (vec 0x203) and redirect (0x400) same cycle: pc_out=0x200, no misaligned pulse.
// 6 pc_out=0xFFFFFFFC fetch completes -> pc_out=0x0. Also assert rst_in in WAIT: pc_out=BOOT_ADDR immediately, state BOOT.

Source files
------------

// File: rtl/msrv32_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_pc_fetch_ctrl
// Brief    : PC register and single-outstanding instruction-fetch controller
//            with trap/redirect priority and in-flight response kill.
// Revision : 1.0 - initial release
// ============================================================================
module msrv32_pc_fetch_ctrl #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] BOOT_ADDR   = '0,
    parameter int unsigned     RESET_DELAY = 2,
    parameter int unsigned     CNT_W       = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             trap_in,
    input  logic [XLEN-1:0]  trap_vec_in,
    input  logic             redirect_in,
    input  logic [XLEN-1:0]  redirect_pc_in,
    input  logic             stall_in,
    output logic             imem_req_out,
    output logic [XLEN-1:0]  imem_addr_out,
    input  logic             imem_gnt_in,
    input  logic             imem_rvalid_in,
    input  logic [31:0]      imem_rdata_in,
    output logic [XLEN-1:0]  pc_out,
    output logic [31:0]      instr_out,
    output logic [XLEN-1:0]  instr_pc_out,
    output logic             instr_valid_out,
    output logic             misaligned_out,
    output logic [XLEN-1:0]  misaligned_addr_out,
    output logic [CNT_W-1:0] fetch_cnt_out
);

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_KILL = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    localparam logic [31:0] c_DLY_LAST = (RESET_DELAY > 0) ? 32'(RESET_DELAY - 1) : 32'd0;

    state_t             r_state;
    logic [XLEN-1:0]    r_pc;
    logic [31:0]        r_instr;
    logic [XLEN-1:0]    r_instr_pc;
    logic               r_valid;
    logic               r_mis;
    logic [XLEN-1:0]    r_mis_addr;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_delay;

    logic               w_redir_aligned;
    logic               w_redir_bad;
    logic               w_upd;
    logic [XLEN-1:0]    w_upd_pc;
    logic               w_boot_done;

    // Trap beats redirect; a misaligned redirect is only reported when no trap hides it.
    assign w_redir_aligned = redirect_in && (redirect_pc_in[1:0] == 2'b00);
    assign w_redir_bad     = redirect_in && !trap_in && (redirect_pc_in[1:0] != 2'b00);
    assign w_upd           = trap_in || w_redir_aligned;
    assign w_upd_pc        = trap_in ? (trap_vec_in & ~XLEN'(3)) : redirect_pc_in;
    assign w_boot_done     = (r_delay >= c_DLY_LAST);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= S_BOOT;
            r_pc       <= BOOT_ADDR;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_mis      <= 1'b0;
            r_mis_addr <= '0;
            r_cnt      <= '0;
            r_delay    <= '0;
        end else begin
            r_mis <= w_redir_bad;
            if (w_redir_bad) begin
                r_mis_addr <= redirect_pc_in;
            end

            case (r_state)
                S_BOOT: begin
                    if (w_upd) begin
                        r_pc <= w_upd_pc;
                    end
                    if (w_boot_done) begin
                        r_state <= S_REQ;
                    end else begin
                        r_delay <= r_delay + 32'd1;
                    end
                end

                S_REQ: begin
                    if (w_upd) begin
                        r_pc <= w_upd_pc;
                        if (imem_gnt_in) begin
                            r_state <= S_KILL;
                        end
                    end else if (imem_gnt_in) begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (w_upd) begin
                        r_pc    <= w_upd_pc;
                        r_state <= imem_rvalid_in ? S_REQ : S_KILL;
                    end else if (imem_rvalid_in) begin
                        r_instr    <= imem_rdata_in;
                        r_instr_pc <= r_pc;
                        r_valid    <= 1'b1;
                        r_pc       <= r_pc + XLEN'(4);
                        r_state    <= S_HOLD;
                    end
                end

                // Response here belongs to a discarded request: drop it.
                S_KILL: begin
                    if (w_upd) begin
                        r_pc <= w_upd_pc;
                    end
                    if (imem_rvalid_in) begin
                        r_state <= S_REQ;
                    end
                end

                S_HOLD: begin
                    if (w_upd) begin
                        r_pc    <= w_upd_pc;
                        r_valid <= 1'b0;
                        r_state <= S_REQ;
                    end else if (r_valid && !stall_in) begin
                        r_valid <= 1'b0;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= S_REQ;
                    end
                end

                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    assign imem_req_out        = (r_state == S_REQ);
    assign imem_addr_out       = r_pc;
    assign pc_out              = r_pc;
    assign instr_out           = r_instr;
    assign instr_pc_out        = r_instr_pc;
    assign instr_valid_out     = r_valid;
    assign misaligned_out      = r_mis;
    assign misaligned_addr_out = r_mis_addr;
    assign fetch_cnt_out       = r_cnt;

endmodule
`default_nettype wire
